hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 32 +++
 rtl/hazard_controller_sat_counter.sv | 35 +++
 rtl/hazard_controller.sv | 198 +++++++++++++++++++
 tb/tb_hazard_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller_pkg
//  Description : Shared pipeline definitions. This package holds the register
//                file constants, the hazard-controller state encodings and the
//                default memory watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_controller_pkg;

    // Architectural register x0 is hard-wired to zero and is never a real producer
    localparam logic [4:0] c_reg_x0 = 5'd0;

    // Default number of MEM_WAIT cycles before the watchdog trips
    localparam int c_mem_timeout_default = 255;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BR_FLUSH = 2'd2
    } hz_state_t;

    // True when an ID source operand is read and names the EX destination
    function automatic logic src_match(input logic [4:0] src_addr,
                                       input logic       src_valid,
                                       input logic [4:0] dst_addr);
        return src_valid && (src_addr == dst_addr);
    endfunction

endpackage : hazard_controller_pkg
`default_nettype wire

// File: rtl/hazard_controller_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter. The counter adds one per cycle while
//                inc is high and holds at all-ones. clear zeroes it
//                synchronously.
//  Ports       : clk, rst (async, active-high), clear, inc -> count[WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline hazard control. The block resolves memory stalls,
//                taken-branch flushes and load-use interlocks with a fixed
//                priority of mem_block > branch > load_use. It also runs a
//                sticky memory watchdog and keeps saturating stall and flush
//                counters.
//  Ports       : in  - clk, rst, rs1/rs2 addr+valid (ID), rd_addr_ex,
//                      rd_valid_ex, is_load_ex, branch_taken_ex,
//                      dmem_req_mem, dmem_ready
//                out - stall_if/id/ex/mem, flush_id/ex, bubble_ex,
//                      mem_timeout, stall_count[31:0], flush_count[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = c_mem_timeout_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_id,
    input  logic [4:0]  rs2_addr_id,
    input  logic        rs1_valid_id,
    input  logic        rs2_valid_id,
    input  logic [4:0]  rd_addr_ex,
    input  logic        rd_valid_ex,
    input  logic        is_load_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        bubble_ex,
    output logic        mem_timeout,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [7:0] c_timeout_limit = 8'(MEM_TIMEOUT);

    hz_state_t  r_state;
    hz_state_t  w_state_next;
    logic       r_branch_pending;
    logic       w_branch_pending_next;
    logic [7:0] r_wd_count;
    logic [7:0] w_wd_inc;
    logic       r_mem_timeout;

    logic w_mem_block;
    logic w_load_use;
    logic w_branch;

    logic w_stall_if;
    logic w_stall_id;
    logic w_stall_ex;
    logic w_stall_mem;
    logic w_flush_id;
    logic w_flush_ex;
    logic w_bubble_ex;

    assign w_mem_block = dmem_req_mem && !dmem_ready;
    assign w_load_use  = rd_valid_ex && is_load_ex && (rd_addr_ex != c_reg_x0) &&
                         (src_match(rs1_addr_id, rs1_valid_id, rd_addr_ex) ||
                          src_match(rs2_addr_id, rs2_valid_id, rd_addr_ex));
    // A redirect is needed for a live branch or for one that was held back by a stall
    assign w_branch    = branch_taken_ex || r_branch_pending;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_branch_pending <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_branch_pending <= w_branch_pending_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next          = ST_RUN;
        w_branch_pending_next = 1'b0;
        w_stall_if            = 1'b0;
        w_stall_id            = 1'b0;
        w_stall_ex            = 1'b0;
        w_stall_mem           = 1'b0;
        w_flush_id            = 1'b0;
        w_flush_ex            = 1'b0;
        w_bubble_ex           = 1'b0;

        if (w_mem_block) begin
            // The whole pipe freezes. A redirect arriving now is remembered and
            // is serviced after the memory releases.
            w_stall_if            = 1'b1;
            w_stall_id            = 1'b1;
            w_stall_ex            = 1'b1;
            w_stall_mem           = 1'b1;
            w_state_next          = ST_MEM_WAIT;
            w_branch_pending_next = r_branch_pending || branch_taken_ex;
        end else begin
            case (r_state)
                ST_MEM_WAIT: begin
                    // Release cycle: the stalls simply drop. Any redirect
                    // collected during the wait is serviced in BR_FLUSH.
                    w_state_next = w_branch ? ST_BR_FLUSH : ST_RUN;
                end
                ST_BR_FLUSH: begin
                    if (w_branch) begin
                        w_flush_id   = 1'b1;
                        w_flush_ex   = 1'b1;
                        w_state_next = ST_BR_FLUSH;
                    end else begin
                        // Discard the single wrong-path fetch now sitting in ID
                        w_flush_id   = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    if (w_branch) begin
                        w_flush_id   = 1'b1;
                        w_flush_ex   = 1'b1;
                        w_state_next = ST_BR_FLUSH;
                    end else if (w_load_use) begin
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    // Reset masks every control output so the pipe sees no requests while held
    assign stall_if  = w_stall_if  && !rst;
    assign stall_id  = w_stall_id  && !rst;
    assign stall_ex  = w_stall_ex  && !rst;
    assign stall_mem = w_stall_mem && !rst;
    assign flush_id  = w_flush_id  && !rst;
    assign flush_ex  = w_flush_ex  && !rst;
    assign bubble_ex = w_bubble_ex && !rst;

    // ------------------------------------------------------------------------
    // Memory watchdog. The counter holds the number of consecutive cycles spent
    // in MEM_WAIT, counting the current one. It trips when that reaches the limit.
    // ------------------------------------------------------------------------
    assign w_wd_inc = (r_wd_count == 8'hFF) ? 8'hFF : (r_wd_count + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_count    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else if (w_state_next == ST_MEM_WAIT) begin
            r_wd_count <= w_wd_inc;
            if (w_wd_inc >= c_timeout_limit) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_wd_count <= 8'd0;
        end
    end

    assign mem_timeout = r_mem_timeout;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    sat_counter #(
        .WIDTH (32)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (stall_if),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (16)
    ) u_flush_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (flush_id),
        .count (flush_count)
    );

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Scoreboard bench for hazard_controller. The stimulus process
//                drives one vector per cycle and queues the hand-computed
//                response. A separate monitor pops that response and compares
//                it with the DUT on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    // Control vector: {stall_if, stall_id, stall_ex, stall_mem,
    //                  flush_id, flush_ex, bubble_ex, mem_timeout}
    localparam logic [7:0] c_none = 8'b0000_0000;
    localparam logic [7:0] c_lu   = 8'b1100_0010;
    localparam logic [7:0] c_br   = 8'b0000_1100;
    localparam logic [7:0] c_bf   = 8'b0000_1000;
    localparam logic [7:0] c_mem  = 8'b1111_0000;
    localparam logic [7:0] c_memt = 8'b1111_0001;
    localparam logic [7:0] c_to   = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr_id = '0;
    logic [4:0]  rs2_addr_id = '0;
    logic        rs1_valid_id = 1'b0;
    logic        rs2_valid_id = 1'b0;
    logic [4:0]  rd_addr_ex = '0;
    logic        rd_valid_ex = 1'b0;
    logic        is_load_ex = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic        dmem_req_mem = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, bubble_ex, mem_timeout;
    logic [31:0] stall_count;
    logic [15:0] flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic [7:0]  ctl;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    hazard_controller #(
        .MEM_TIMEOUT (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_addr_id     (rs1_addr_id),
        .rs2_addr_id     (rs2_addr_id),
        .rs1_valid_id    (rs1_valid_id),
        .rs2_valid_id    (rs2_valid_id),
        .rd_addr_ex      (rd_addr_ex),
        .rd_valid_ex     (rd_valid_ex),
        .is_load_ex      (is_load_ex),
        .branch_taken_ex (branch_taken_ex),
        .dmem_req_mem    (dmem_req_mem),
        .dmem_ready      (dmem_ready),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .stall_ex        (stall_ex),
        .stall_mem       (stall_mem),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .bubble_ex       (bubble_ex),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // Monitor: one queued response is checked per falling edge
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {stall_if, stall_id, stall_ex, stall_mem,
                       flush_id, flush_ex, bubble_ex, mem_timeout};
                n_tests++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
                end
                n_tests++;
                if ((stall_count !== e.sc) || (flush_count !== e.fc)) begin
                    n_fail++;
                    $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.nm, stall_count, flush_count, e.sc, e.fc);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic r,
                       input logic [4:0] a1, input logic v1,
                       input logic [4:0] a2, input logic v2,
                       input logic [4:0] rd, input logic rdv, input logic ld,
                       input logic br, input logic req, input logic rdy,
                       input logic [7:0] ctl, input logic [31:0] sc, input logic [15:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        rs1_addr_id     = a1;
        rs1_valid_id    = v1;
        rs2_addr_id     = a2;
        rs2_valid_id    = v2;
        rd_addr_ex      = rd;
        rd_valid_ex     = rdv;
        is_load_ex      = ld;
        branch_taken_ex = br;
        dmem_req_mem    = req;
        dmem_ready      = rdy;
        e.nm  = nm;
        e.ctl = ctl;
        e.sc  = sc;
        e.fc  = fc;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [7:0] ctl,
                        input logic [31:0] sc, input logic [15:0] fc);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, sc, fc);
    endtask

    task automatic do_reset(input string nm);
        cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_none, 0, 0);
    endtask

    initial begin
        // Load-use: EX loads x5, ID reads x5 through rs2
        do_reset("rst_a");
        cyc("lu_stall",       0, 0, 0, 5, 1, 5, 1, 1, 0, 0, 0, c_lu,   0, 0);
        idle("lu_release",                                          c_none, 1, 0);
        cyc("lu_rs1_invalid", 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, c_none, 1, 0);
        cyc("lu_not_load",    0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, c_none, 1, 0);
        cyc("lu_rd_invalid",  0, 5, 1, 0, 0, 5, 0, 1, 0, 0, 0, c_none, 1, 0);
        cyc("lu_rs1_match",   0, 7, 1, 0, 0, 7, 1, 1, 0, 0, 0, c_lu,   1, 0);
        idle("lu_rs1_after",                                        c_none, 2, 0);
        // A load to x0 never interlocks
        cyc("load_x0",        0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, c_none, 2, 0);

        // Branch: one redirect cycle, then one wrong-path flush
        do_reset("rst_c");
        cyc("br_taken",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,   0, 0);
        idle("br_flush",                                            c_bf,   0, 1);
        idle("br_done",                                             c_none, 0, 2);
        cyc("br_lu_suppr",    0, 0, 0, 5, 1, 5, 1, 1, 1, 0, 0, c_br,   0, 2);
        cyc("br_lu_flush",    0, 0, 0, 5, 1, 5, 1, 1, 0, 0, 0, c_bf,   0, 3);
        cyc("br_again",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,   0, 4);
        cyc("br_in_brflush",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br,   0, 5);
        idle("br_tail",                                             c_bf,   0, 6);
        idle("br_end",                                              c_none, 0, 7);

        // Memory stall held 4 cycles; the 4th is the 3rd MEM_WAIT cycle
        do_reset("rst_d");
        cyc("mem1",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  0, 0);
        cyc("mem2",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  1, 0);
        cyc("mem3",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  2, 0);
        cyc("mem4",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_memt, 3, 0);
        cyc("mem_release",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_to,   4, 0);
        cyc("mem_run",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_br | c_to, 4, 0);
        idle("mem_run_tail",                                        c_bf | c_to, 4, 1);

        // Memory stall, branch and load-use arrive together
        do_reset("rst_f");
        cyc("sim1",           0, 0, 0, 5, 1, 5, 1, 1, 1, 1, 0, c_mem,  0, 0);
        cyc("sim2",           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  1, 0);
        cyc("sim_release",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_none, 2, 0);
        idle("sim_brflush",                                         c_bf,   2, 0);
        idle("sim_done",                                            c_none, 2, 1);

        // Watchdog trips, then reset lands mid-wait
        do_reset("rst_e");
        cyc("to1",            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  0, 0);
        cyc("to2",            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  1, 0);
        cyc("to3",            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_mem,  2, 0);
        cyc("to4",            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_memt, 3, 0);
        cyc("to5",            0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, c_memt, 4, 0);
        cyc("to_rst",         1, 0, 0, 5, 1, 5, 1, 1, 1, 1, 0, c_none, 0, 0);
        idle("to_after",                                            c_none, 0, 0);
        cyc("to_run",         0, 0, 0, 5, 1, 5, 1, 1, 0, 0, 0, c_lu,   0, 0);
        idle("to_end",                                              c_none, 1, 0);

        for (int i = 0; (i < 10) && (q.size() > 0); i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_controller
`default_nettype wire
